// File: rtl/rv_mem_arbiter_if.sv
// rv_mem request channel: op encoding package and valid/ready interface.
// Ports: valid, ready, block, op, addr, data; modport in (sink), out (source).
package rv_mem_pkg;
  localparam logic RV_MEM_READ  = 1'b0;
  localparam logic RV_MEM_WRITE = 1'b1;
endpackage

interface rv_mem_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  valid;
  logic                  ready;
  logic                  block;
  logic                  op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport in  (input  valid, block, op, addr, data, output ready);
  modport out (output valid, block, op, addr, data, input  ready);
endinterface

// File: rtl/rv_mem_arbiter.sv
// Round-robin two-requester memory arbiter with lock and in-order read routing.
// Ports: clk, rst, req0/req1 (in), mem (out), mem_rsp_*, rsp0_*/rsp1_*, rsp_error.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_mem_intf.in                req0,
  rv_mem_intf.in                req1,
  rv_mem_intf.out               mem,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  input  logic                  rsp0_ready,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp_error
);

  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic                  r_valid;
  logic                  r_block;
  logic                  r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  r_ptr;
  logic                  r_lock;
  logic                  r_owner;
  logic                  r_error;

  logic [TAG_DEPTH-1:0]  r_tag;
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_can_load;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_rdy0;
  logic                  w_rdy1;
  logic                  w_acc;
  logic                  w_id;
  logic                  w_acc_op;
  logic                  w_acc_blk;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full is the pre-pop view, so a same-cycle pop never admits a read.
  assign w_full     = (r_cnt == CW'(TAG_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_can_load = ~r_valid | mem.ready;

  assign w_elig0 = req0.valid & ((req0.op == RV_MEM_WRITE) | ~w_full);
  assign w_elig1 = req1.valid & ((req1.op == RV_MEM_WRITE) | ~w_full);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_lock) begin
      w_gnt0 = ~r_owner & w_elig0;
      w_gnt1 = r_owner & w_elig1;
    end else if (w_elig0 & w_elig1) begin
      w_gnt0 = ~r_ptr;
      w_gnt1 = r_ptr;
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
  end

  assign w_rdy0     = ~rst & w_can_load & w_gnt0;
  assign w_rdy1     = ~rst & w_can_load & w_gnt1;
  assign req0.ready = w_rdy0;
  assign req1.ready = w_rdy1;

  // A ready is only raised toward an eligible (valid) requester.
  assign w_acc      = w_rdy0 | w_rdy1;
  assign w_id       = w_rdy1;
  assign w_acc_op   = w_id ? req1.op    : req0.op;
  assign w_acc_blk  = w_id ? req1.block : req0.block;
  assign w_acc_addr = w_id ? req1.addr  : req0.addr;
  assign w_acc_data = w_id ? req1.data  : req0.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_can_load) begin
      r_valid <= w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_can_load & w_acc) begin
      r_op    <= w_acc_op;
      r_block <= w_acc_blk;
      r_addr  <= w_acc_addr;
      r_data  <= w_acc_data;
    end
  end

  assign mem.valid = r_valid;
  assign mem.op    = r_op;
  assign mem.block = r_block;
  assign mem.addr  = r_addr;
  assign mem.data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_lock  <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_acc) begin
      r_ptr <= ~w_id;
      if (w_acc_blk) begin
        r_lock  <= 1'b1;
        r_owner <= w_id;
      end else if (r_lock & (r_owner == w_id)) begin
        r_lock <= 1'b0;
      end
    end
  end

  assign w_push = w_acc & (w_acc_op == RV_MEM_READ);
  assign w_head = r_tag[r_rd];

  assign mem_rsp_ready = w_empty | (w_head ? rsp1_ready : rsp0_ready);
  assign w_pop         = mem_rsp_valid & mem_rsp_ready & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      if (w_push & ~w_pop) r_cnt <= r_cnt + CW'(1);
      if (~w_push & w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wr] <= w_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (mem_rsp_valid & w_empty) begin
      r_error <= 1'b1;
    end
  end

  assign rsp_error  = r_error;
  assign rsp0_valid = ~rst & ~w_empty & ~w_head & mem_rsp_valid;
  assign rsp1_valid = ~rst & ~w_empty & w_head & mem_rsp_valid;
  assign rsp0_data  = mem_rsp_data;
  assign rsp1_data  = mem_rsp_data;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: directed scenarios plus random traffic.
// Reference model tracks slot, pointer, lock and outstanding reads as queues.
module tb_rv_mem_arbiter;
  import rv_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mem_rsp_valid;
  logic          mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic          rsp0_ready;
  logic          rsp1_ready;
  logic [DW-1:0] rsp0_data;
  logic [DW-1:0] rsp1_data;
  logic          rsp_error;

  rv_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0_if ();
  rv_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1_if ();
  rv_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_if ();

  rv_mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (r0_if),
    .req1         (r1_if),
    .mem          (m_if),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data (mem_rsp_data),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp1_ready   (rsp1_ready),
    .rsp0_data    (rsp0_data),
    .rsp1_data    (rsp1_data),
    .rsp_error    (rsp_error)
  );

  typedef struct packed {
    logic          op;
    logic          blk;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t         exp_mem[$];
  logic          exp_id[$];
  logic [DW-1:0] exp_rsp0[$];
  logic [DW-1:0] exp_rsp1[$];
  logic [DW-1:0] mem_pend[$];

  logic  m_slot;
  xfer_t m_slot_x;
  logic  m_ptr;
  logic  m_lock;
  logic  m_owner;
  logic  m_err;

  logic          s_rst;
  logic          s_v[2];
  logic          s_op[2];
  logic          s_blk[2];
  logic [AW-1:0] s_addr[2];
  logic [DW-1:0] s_data[2];
  logic          s_mready;
  logic          s_rr[2];
  logic          s_go;
  logic          s_force;

  int n_cmp = 0;
  int n_bad = 0;

  xfer_t         mon_x;
  logic [DW-1:0] mon_d;

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {22'd0, a ^ 10'h010};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  task automatic idle();
    s_rst    = 1'b0;
    s_mready = 1'b1;
    s_go     = 1'b0;
    s_force  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_v[i]    = 1'b0;
      s_op[i]   = RV_MEM_READ;
      s_blk[i]  = 1'b0;
      s_addr[i] = '0;
      s_data[i] = '0;
      s_rr[i]   = 1'b1;
    end
  endtask

  // One cycle: drive at negedge, check/advance model 1ns later.
  task automatic step();
    logic  full, e0, e1, can, any, g, acc, emr;
    xfer_t x;
    @(negedge clk);
    rst          = s_rst;
    r0_if.valid  = s_v[0];
    r0_if.op     = s_op[0];
    r0_if.block  = s_blk[0];
    r0_if.addr   = s_addr[0];
    r0_if.data   = s_data[0];
    r1_if.valid  = s_v[1];
    r1_if.op     = s_op[1];
    r1_if.block  = s_blk[1];
    r1_if.addr   = s_addr[1];
    r1_if.data   = s_data[1];
    m_if.ready   = s_mready;
    rsp0_ready   = s_rr[0];
    rsp1_ready   = s_rr[1];
    mem_rsp_valid = s_go && (mem_pend.size() > 0 || s_force);
    mem_rsp_data  = (mem_pend.size() > 0) ? mem_pend[0] : 32'h0BAD0BAD;
    #1;
    if (s_rst) begin
      chk("rst_ready0", r0_if.ready, 0);
      chk("rst_ready1", r1_if.ready, 0);
      exp_mem.delete();
      exp_id.delete();
      exp_rsp0.delete();
      exp_rsp1.delete();
      mem_pend.delete();
      m_slot  = 1'b0;
      m_ptr   = 1'b0;
      m_lock  = 1'b0;
      m_owner = 1'b0;
      m_err   = 1'b0;
      return;
    end
    chk("mem_valid", m_if.valid, m_slot);
    chk("rsp_error", rsp_error, m_err);
    full = (exp_id.size() >= TD);
    e0   = s_v[0] && (s_op[0] == RV_MEM_WRITE || !full);
    e1   = s_v[1] && (s_op[1] == RV_MEM_WRITE || !full);
    can  = !m_slot || s_mready;
    if (m_lock) begin
      g   = m_owner;
      any = m_owner ? e1 : e0;
    end else if (e0 && e1) begin
      g   = m_ptr;
      any = 1'b1;
    end else begin
      g   = !e0;
      any = e0 || e1;
    end
    acc = can && any;
    chk("req0_ready", r0_if.ready, acc && !g);
    chk("req1_ready", r1_if.ready, acc && g);
    emr = (exp_id.size() == 0) ? 1'b1 : s_rr[exp_id[0]];
    chk("mem_rsp_ready", mem_rsp_ready, emr);
    chk("rsp0_valid", rsp0_valid,
        exp_id.size() > 0 && mem_rsp_valid && exp_id[0] == 1'b0);
    chk("rsp1_valid", rsp1_valid,
        exp_id.size() > 0 && mem_rsp_valid && exp_id[0] == 1'b1);
    if (mem_rsp_valid && emr) begin
      if (mem_pend.size() > 0) void'(mem_pend.pop_front());
      if (exp_id.size() > 0) void'(exp_id.pop_front());
      else m_err = 1'b1;
    end
    if (m_slot && s_mready && m_slot_x.op == RV_MEM_READ)
      mem_pend.push_back(f(m_slot_x.addr));
    x = '0;
    if (acc) begin
      x.op   = s_op[g];
      x.blk  = s_blk[g];
      x.addr = s_addr[g];
      x.data = s_data[g];
      exp_mem.push_back(x);
      if (x.op == RV_MEM_READ) begin
        exp_id.push_back(g);
        if (g) exp_rsp1.push_back(f(x.addr));
        else   exp_rsp0.push_back(f(x.addr));
      end
      m_ptr = !g;
      if (x.blk) begin
        m_lock  = 1'b1;
        m_owner = g;
      end else if (m_lock && m_owner == g) begin
        m_lock = 1'b0;
      end
    end
    if (can) begin
      m_slot = acc;
      if (acc) m_slot_x = x;
    end
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0) begin
      if (m_if.valid && m_if.ready) begin
        if (exp_mem.size() == 0) fail("mem_xfer_extra");
        else begin
          mon_x = exp_mem.pop_front();
          chk("mem_xfer", {m_if.op, m_if.block, m_if.addr, m_if.data}, mon_x);
        end
      end
      if (rsp0_valid && rsp0_ready) begin
        if (exp_rsp0.size() == 0) fail("rsp0_extra");
        else begin
          mon_d = exp_rsp0.pop_front();
          chk("rsp0_data", rsp0_data, mon_d);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_rsp1.size() == 0) fail("rsp1_extra");
        else begin
          mon_d = exp_rsp1.pop_front();
          chk("rsp1_data", rsp1_data, mon_d);
        end
      end
    end
  end

  int    cnt0, cnt1, n, i0;
  logic  lock_log[$];
  logic  lock_exp[4];
  logic  lock_blk[3];

  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    // single read
    step();
    chk("reset_mem_valid", m_if.valid, 0);
    chk("reset_error", rsp_error, 0);
    s_v[0] = 1'b1; s_op[0] = RV_MEM_READ; s_addr[0] = 10'h010;
    step();
    s_v[0] = 1'b0;
    step();
    chk("sr_valid", m_if.valid, 1);
    chk("sr_addr", m_if.addr, 10'h010);
    chk("sr_op", m_if.op, RV_MEM_READ);
    s_go = 1'b1;
    step();
    chk("sr_rsp0_valid", rsp0_valid, 1);
    chk("sr_rsp1_valid", rsp1_valid, 0);
    chk("sr_rsp_data", rsp0_data, 32'hDEADBEEF);
    s_go = 1'b0;
    step();

    // round-robin
    do_reset();
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_v[i]    = 1'b1;
        s_op[i]   = RV_MEM_WRITE;
        s_addr[i] = AW'($urandom);
        s_data[i] = $urandom;
      end
      step();
      if (c == 0) chk("rr_first", r0_if.ready, 1);
      if (r0_if.ready) cnt0++;
      if (r1_if.ready) cnt1++;
    end
    chk("rr_cnt0", cnt0, 4);
    chk("rr_cnt1", cnt1, 4);
    idle();
    step();

    // lock: three consecutive req0 transfers, then req1
    do_reset();
    lock_blk = '{1'b1, 1'b1, 1'b0};
    lock_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    lock_log.delete();
    i0 = 0;
    for (int c = 0; c < 20 && lock_log.size() < 4; c++) begin
      s_v[0]    = (i0 < 3);
      s_op[0]   = RV_MEM_WRITE;
      s_blk[0]  = (i0 < 3) ? lock_blk[i0] : 1'b0;
      s_data[0] = 32'h1000 + i0;
      s_v[1]    = 1'b1;
      s_op[1]   = RV_MEM_WRITE;
      s_data[1] = 32'h2000 + c;
      step();
      if (r0_if.ready) begin
        lock_log.push_back(1'b0);
        i0++;
      end
      if (r1_if.ready) lock_log.push_back(1'b1);
    end
    if (lock_log.size() < 4) fail("lock_timeout");
    else for (int k = 0; k < 4; k++) chk("lock_seq", lock_log[k], lock_exp[k]);
    idle();
    step();

    // tag FIFO full
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      s_v[1]    = (n < 5);
      s_op[1]   = RV_MEM_READ;
      s_addr[1] = AW'(c);
      step();
      if (r1_if.ready && s_v[1]) n++;
    end
    chk("full_accepts", n, 4);
    s_v[0] = 1'b1; s_op[0] = RV_MEM_WRITE;
    step();
    chk("full_wr_acc", r0_if.ready, 1);
    chk("full_rd_blk", r1_if.ready, 0);
    s_v[0] = 1'b0; s_go = 1'b1;
    step();
    chk("full_pop_blk", r1_if.ready, 0);
    chk("full_pop_rsp", rsp1_valid, 1);
    s_go = 1'b0;
    step();
    chk("full_after_pop", r1_if.ready, 1);
    s_v[1] = 1'b0; s_go = 1'b1;
    for (int c = 0; c < 20 && exp_id.size() > 0; c++) step();
    idle();
    step();

    // backpressure
    s_v[0] = 1'b1; s_op[0] = RV_MEM_WRITE;
    s_addr[0] = 10'h155; s_data[0] = 32'hCAFE0001;
    step();
    s_addr[0] = 10'h0AA; s_data[0] = 32'hCAFE0002;
    s_v[1] = 1'b1; s_op[1] = RV_MEM_WRITE;
    s_mready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_addr", m_if.addr, 10'h155);
      chk("bp_data", m_if.data, 32'hCAFE0001);
      chk("bp_ready0", r0_if.ready, 0);
      chk("bp_ready1", r1_if.ready, 0);
    end
    idle();
    step();

    // interleaved reads 0,1,0 and response stall
    s_v[0] = 1'b1; s_addr[0] = 10'h001;
    step();
    s_v[0] = 1'b0; s_v[1] = 1'b1; s_addr[1] = 10'h002;
    step();
    s_v[1] = 1'b0; s_v[0] = 1'b1; s_addr[0] = 10'h003;
    step();
    s_v[0] = 1'b0;
    step();
    step();
    s_go = 1'b1; s_rr[1] = 1'b0;
    step();
    chk("io_rsp0_a", rsp0_valid, 1);
    step();
    chk("io_rsp1_stall", rsp1_valid, 1);
    chk("io_stall_ready", mem_rsp_ready, 0);
    s_rr[1] = 1'b1;
    step();
    chk("io_rsp1", rsp1_valid, 1);
    step();
    chk("io_rsp0_b", rsp0_valid, 1);
    s_go = 1'b0;
    step();

    // unexpected response sets sticky error
    s_go = 1'b1; s_force = 1'b1;
    step();
    chk("err_rsp_ready", mem_rsp_ready, 1);
    s_go = 1'b0; s_force = 1'b0;
    step();
    chk("err_set", rsp_error, 1);
    step();
    step();
    chk("err_sticky", rsp_error, 1);

    // reset with reads outstanding
    s_v[0] = 1'b1; s_addr[0] = 10'h005;
    step();
    s_v[0] = 1'b0; s_v[1] = 1'b1; s_addr[1] = 10'h006;
    step();
    s_v[1] = 1'b0;
    step();
    do_reset();
    step();
    chk("rst_err_clr", rsp_error, 0);
    chk("rst_fifo_empty", mem_rsp_ready, 1);
    s_v[0] = 1'b1; s_op[0] = RV_MEM_WRITE;
    s_v[1] = 1'b1; s_op[1] = RV_MEM_WRITE;
    step();
    chk("rst_ptr0", r0_if.ready, 1);
    chk("rst_ptr1", r1_if.ready, 0);
    idle();
    s_go = 1'b1; s_force = 1'b1;
    step();
    s_go = 1'b0; s_force = 1'b0;
    step();
    chk("post_rst_err", rsp_error, 1);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_v[i]    = $urandom_range(0, 1);
        s_op[i]   = $urandom_range(0, 1);
        s_blk[i]  = ($urandom_range(0, 3) == 0);
        s_addr[i] = AW'($urandom);
        s_data[i] = $urandom;
        s_rr[i]   = ($urandom_range(0, 3) != 0);
      end
      s_mready = ($urandom_range(0, 3) != 0);
      s_go     = $urandom_range(0, 1);
      step();
    end
    idle();
    s_go = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("drain_mem", exp_mem.size(), 0);
    chk("drain_rsp0", exp_rsp0.size(), 0);
    chk("drain_rsp1", exp_rsp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
